// File: rtl/d18_frame_collector.sv
// rtl/d18_frame_collector.sv - 1-to-N demultiplexing frame collector with valid/ready output
//
// Purpose: routes each accepted serial beat (din, lane select s) into lane s
// of an N-bit frame register. Once every lane has been written at least once,
// the assembled frame is presented on out with out_valid and held until the
// consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din        data bit for the addressed lane
//   s          lane select for din (SEL_W bits)
//   in_valid   beat valid
//   in_ready   collector can accept a beat (high while collecting)
//   clr        synchronous abort of the partial frame (ignored while holding)
//   out        assembled frame, bit k = last din accepted with s == k
//   out_valid  frame available
//   out_ready  consumer accepts frame
//   fill       number of distinct lanes written in the current partial frame
//   dup_err    one-cycle pulse after a beat rewrote an already-written lane

module d18_frame_collector #(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [SEL_W-1:0] s,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [(1<<SEL_W)-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W:0]   fill,
  output logic             dup_err
);

  localparam int N = 1 << SEL_W;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [N-1:0]   out_q, out_d;
  logic [SEL_W:0] fill_q, fill_d;
  logic           dup_q, dup_d;

  logic [N-1:0]   new_mask;
  logic [N-1:0]   new_data;
  logic           beat_accept;

  function automatic logic [SEL_W:0] popcount(input logic [N-1:0] v);
    logic [SEL_W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{SEL_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  assign in_ready    = (state_q == COLLECT);
  assign out_valid   = (state_q == HOLD);
  assign beat_accept = in_valid && in_ready && !clr;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mask_d   = mask_q;
    out_d    = out_q;
    fill_d   = fill_q;
    dup_d    = 1'b0;

    // Frame as it would look if the current beat were taken.
    new_mask    = mask_q;
    new_data    = data_q;
    new_mask[s] = 1'b1;
    new_data[s] = din;

    case (state_q)
      COLLECT: begin
        if (clr) begin
          // Abort wins over a simultaneous beat; out keeps the last frame.
          data_d = '0;
          mask_d = '0;
          fill_d = '0;
        end else if (beat_accept) begin
          dup_d = mask_q[s];
          if (&new_mask) begin
            state_d = HOLD;
            out_d   = new_data;
            data_d  = '0;
            mask_d  = '0;
            fill_d  = '0;
          end else begin
            data_d = new_data;
            mask_d = new_mask;
            fill_d = popcount(new_mask);
          end
        end
      end
      HOLD: begin
        // No bypass: the handshake cycle itself never accepts a beat.
        if (out_ready) begin
          state_d = COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      data_q  <= '0;
      mask_q  <= '0;
      out_q   <= '0;
      fill_q  <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
      fill_q  <= fill_d;
      dup_q   <= dup_d;
    end
  end

  assign out     = out_q;
  assign fill    = fill_q;
  assign dup_err = dup_q;

endmodule

// File: tb/tb_d18_frame_collector.sv
// tb/tb_d18_frame_collector.sv - self-checking bench for d18_frame_collector

module tb_d18_frame_collector;

  logic       clk;
  logic       rst;
  logic       din;
  logic [2:0] s;
  logic       in_valid;
  logic       in_ready;
  logic       clr;
  logic [7:0] out_w;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fill;
  logic       dup_err;

  int checks_cnt;
  int errors_cnt;

  // Reference model: a frame is "the set of lanes written so far" plus the
  // last value written to each lane; it completes when the set holds 8 lanes.
  bit         m_hold;
  logic [7:0] m_out;
  int         m_lanes[$];
  bit         m_vals[8];
  bit         m_dup;

  d18_frame_collector #(.SEL_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .s         (s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clr       (clr),
    .out       (out_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill),
    .dup_err   (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("m_in_ready",  32'(in_ready),  32'(!m_hold));
    check("m_out_valid", 32'(out_valid), 32'(m_hold));
    check("m_out",       32'(out_w),     32'(m_out));
    check("m_fill",      32'(fill),      32'(m_lanes.size()));
    check("m_dup_err",   32'(dup_err),   32'(m_dup));
  endtask

  // Compare at the falling edge, apply the new inputs, advance the model
  // to what the next rising edge should produce.
  task automatic step(input logic r, input logic c, input logic v,
                      input logic [2:0] sel, input logic d, input logic ordy);
    bit found;
    bit dup_n;
    @(negedge clk);
    compare_model();
    rst = r; clr = c; in_valid = v; s = sel; din = d; out_ready = ordy;
    dup_n = 1'b0;
    if (r) begin
      m_hold = 1'b0;
      m_out  = 8'h00;
      m_lanes.delete();
      for (int i = 0; i < 8; i++) m_vals[i] = 1'b0;
    end else if (!m_hold) begin
      if (c) begin
        m_lanes.delete();
      end else if (v) begin
        found = 1'b0;
        foreach (m_lanes[i]) if (m_lanes[i] == int'(sel)) found = 1'b1;
        dup_n = found;
        m_vals[sel] = d;
        if (!found) m_lanes.push_back(int'(sel));
        if (m_lanes.size() == 8) begin
          for (int i = 0; i < 8; i++) m_out[i] = m_vals[i];
          m_hold = 1'b1;
          m_lanes.delete();
        end
      end
    end else if (ordy) begin
      m_hold = 1'b0;
    end
    m_dup = dup_n;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic handshake();
    // A beat is offered during the handshake; it must not be taken.
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] val);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 3'(k), val[k], 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    checks_cnt = 0;
    errors_cnt = 0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; s = '0; din = 1'b0; out_ready = 1'b0;
    m_hold = 1'b0; m_out = 8'h00; m_dup = 1'b0;
    for (int i = 0; i < 8; i++) m_vals[i] = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    settle();
    check("rst_out", 32'(out_w), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fill", 32'(fill), 32'd0);

    // Walking one-hot: din=1 only on lane 3
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 3'(k), (k == 3), 1'b0);
    settle();
    check("walk_out", 32'(out_w), 32'h08);
    check("walk_out_valid", 32'(out_valid), 32'd1);
    check("walk_in_ready", 32'(in_ready), 32'd0);
    check("walk_fill", 32'(fill), 32'd0);
    handshake();
    settle();
    check("walk_hs_valid", 32'(out_valid), 32'd0);
    check("walk_hs_ready", 32'(in_ready), 32'd1);
    check("walk_hs_fill", 32'(fill), 32'd0);
    check("walk_hs_out", 32'(out_w), 32'h08);

    // Reverse order, all ones
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b1, 3'(7 - k), 1'b1, 1'b0);
      settle();
      if (k < 7) begin
        check("rev_fill", 32'(fill), 32'(k + 1));
        check("rev_no_valid", 32'(out_valid), 32'd0);
      end
    end
    check("rev_out", 32'(out_w), 32'hFF);
    check("rev_out_valid", 32'(out_valid), 32'd1);
    handshake();

    // Duplicate lane
    step(1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    settle();
    check("dup_pulse", 32'(dup_err), 32'd1);
    check("dup_fill", 32'(fill), 32'd1);
    idle();
    settle();
    check("dup_one_cycle", 32'(dup_err), 32'd0);
    for (int k = 0; k < 8; k++) if (k != 2) step(1'b0, 1'b0, 1'b1, 3'(k), 1'b0, 1'b0);
    settle();
    check("dup_out", 32'(out_w), 32'h00);
    check("dup_out_valid", 32'(out_valid), 32'd1);
    handshake();

    // Backpressure
    send_frame(8'hA5);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
      settle();
      check("bp_out", 32'(out_w), 32'hA5);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_fill", 32'(fill), 32'd0);
    end
    handshake();
    settle();
    check("bp_after_fill", 32'(fill), 32'd0);
    step(1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    settle();
    check("bp_next_fill", 32'(fill), 32'd1);

    // clr mid-frame (also discards the lane-1 beat above)
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 3'(k), 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
    settle();
    check("clr_fill", 32'(fill), 32'd0);
    check("clr_dup", 32'(dup_err), 32'd0);
    check("clr_out_kept", 32'(out_w), 32'hA5);
    send_frame(8'h0F);
    settle();
    check("clr_out", 32'(out_w), 32'h0F);
    handshake();

    // Reset in HOLD, then in COLLECT with fill=4
    send_frame(8'h3C);
    settle();
    check("rsth_pre", 32'(out_w), 32'h3C);
    step(1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    settle();
    check("rsth_out", 32'(out_w), 32'h00);
    check("rsth_valid", 32'(out_valid), 32'd0);
    check("rsth_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 3'(k), 1'b1, 1'b0);
    settle();
    check("rstc_pre_fill", 32'(fill), 32'd4);
    step(1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    settle();
    check("rstc_fill", 32'(fill), 32'd0);
    check("rstc_dup", 32'(dup_err), 32'd0);
    check("rstc_ready", 32'(in_ready), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      pat = 8'($urandom);
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)),
           pat[0],
           ($urandom_range(0, 1) == 1));
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
